nvme_cmd_id_alloc: RTL and testbench

//  Upstream/companion of the NVMe IO completion tracker. Allocates 16-bit NVMe command ids
//  {req_id, action_id, sq_id}, req_id issued in order per action and wrapping at TRACK_NUM
//  to match the tracker's per-action read index. Caps outstanding commands per action at TRACK_NUM.

---
 rtl/nvme_cmd_id_alloc.sv | 245 ++++++++++++++++++++++++
 tb/tb_nvme_cmd_id_alloc.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvme_cmd_id_alloc.sv
// -----------------------------------------------------------------------------
// nvme_cmd_id_alloc
//
// Hands out 16-bit NVMe command ids {req_id, action_id, sq_id} to actions.
// req_id is issued in order per action and wraps at TRACK_NUM, so it lines up
// with the completion tracker's per-action read index. The number of
// outstanding commands per action is capped at TRACK_NUM. A small retire FSM
// polls the tracker on behalf of an action, retires completed commands and
// returns the tracker status to the action.
//
// Ports
//   axi_aclk / axi_aresetn      clock, synchronous active-low reset
//   track_init                  tracker memory is initialised; gates all activity
//   alloc_valid/ready           id request from an action (ready is combinational)
//   alloc_action_id/sq_id       requesting action and target submission queue
//   cmd_valid/ready, cmd_id     allocated id towards the SQ writer
//   cpl_req_valid/ready/id      action asks for its next completion
//   cpl_rsp_valid/ready/data    completion result: [0]=completed, [1]=status!=0
//   track_update, _id           one-cycle pulse + action id towards the tracker
//   track_update_done/_data     tracker result strobe and result
//   action_busy                 bit i set while action i has commands outstanding
//   underflow_err               sticky: a retire was seen with nothing outstanding
// -----------------------------------------------------------------------------
module nvme_cmd_id_alloc #(
    parameter int ACTION_ID_BITS = 4,
    parameter int QUEUE_ID_BITS  = 4,
    parameter int REQ_ID_BITS    = 8,
    parameter int TRACK_NUM      = 8
) (
    input  logic                                                axi_aclk,
    input  logic                                                axi_aresetn,
    input  logic                                                track_init,
    input  logic                                                alloc_valid,
    output logic                                                alloc_ready,
    input  logic [ACTION_ID_BITS-1:0]                           alloc_action_id,
    input  logic [QUEUE_ID_BITS-1:0]                            alloc_sq_id,
    output logic                                                cmd_valid,
    input  logic                                                cmd_ready,
    output logic [REQ_ID_BITS+ACTION_ID_BITS+QUEUE_ID_BITS-1:0] cmd_id,
    input  logic                                                cpl_req_valid,
    output logic                                                cpl_req_ready,
    input  logic [ACTION_ID_BITS-1:0]                           cpl_req_id,
    output logic                                                cpl_rsp_valid,
    input  logic                                                cpl_rsp_ready,
    output logic [1:0]                                          cpl_rsp_data,
    output logic                                                track_update,
    output logic [ACTION_ID_BITS-1:0]                           track_update_id,
    input  logic                                                track_update_done,
    input  logic [1:0]                                          track_update_data,
    output logic [2**ACTION_ID_BITS-1:0]                        action_busy,
    output logic                                                underflow_err
);

    localparam int NUM_ACT  = 2**ACTION_ID_BITS;
    localparam int CMD_BITS = REQ_ID_BITS + ACTION_ID_BITS + QUEUE_ID_BITS;
    // Counter must be able to hold TRACK_NUM itself (the "full" value).
    localparam int CNT_BITS = $clog2(TRACK_NUM + 1);

    localparam logic [CNT_BITS-1:0]    CNT_MAX  = CNT_BITS'(TRACK_NUM);
    localparam logic [CNT_BITS-1:0]    CNT_ZERO = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0]    CNT_ONE  = CNT_BITS'(1);
    localparam logic [REQ_ID_BITS-1:0] REQ_ZERO = {REQ_ID_BITS{1'b0}};
    localparam logic [REQ_ID_BITS-1:0] REQ_ONE  = REQ_ID_BITS'(1);
    localparam logic [REQ_ID_BITS-1:0] REQ_LAST = REQ_ID_BITS'(TRACK_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UPD  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    // Registered state
    state_t                    state_q, state_d;
    logic                      cmd_valid_q, cmd_valid_d;
    logic [CMD_BITS-1:0]       cmd_id_q, cmd_id_d;
    logic                      track_update_q, track_update_d;
    logic [ACTION_ID_BITS-1:0] track_update_id_q, track_update_id_d;
    logic                      cpl_rsp_valid_q, cpl_rsp_valid_d;
    logic [1:0]                cpl_rsp_data_q, cpl_rsp_data_d;
    logic                      underflow_q, underflow_d;
    logic [NUM_ACT-1:0]        action_busy_q, action_busy_d;
    logic [REQ_ID_BITS-1:0]    req_id_q [NUM_ACT];
    logic [REQ_ID_BITS-1:0]    req_id_d [NUM_ACT];
    logic [CNT_BITS-1:0]       outstanding_q [NUM_ACT];
    logic [CNT_BITS-1:0]       outstanding_d [NUM_ACT];

    // Combinational helpers
    logic               alloc_ready_s;
    logic               alloc_fire_s;
    logic               cpl_req_ready_s;
    logic               retire_fire_s;
    logic               retire_empty_s;
    logic               retire_dec_s;
    logic [NUM_ACT-1:0] alloc_hit_s;
    logic [NUM_ACT-1:0] retire_hit_s;

    // Ready is gated by reset so nothing appears accepted while in reset.
    assign alloc_ready_s   = axi_aresetn & track_init & (~cmd_valid_q | cmd_ready) &
                             (outstanding_q[alloc_action_id] < CNT_MAX);
    assign alloc_fire_s    = alloc_valid & alloc_ready_s;
    assign cpl_req_ready_s = axi_aresetn & track_init & (state_q == S_IDLE);

    // A completed retire only counts while the FSM is genuinely waiting on the tracker.
    assign retire_fire_s   = track_init & (state_q == S_WAIT) & track_update_done & track_update_data[0];
    assign retire_empty_s  = (outstanding_q[track_update_id_q] == CNT_ZERO);
    assign retire_dec_s    = retire_fire_s & ~retire_empty_s;

    // Command id generation and the per-action req_id sequence.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        for (int i = 0; i < NUM_ACT; i++) begin
            req_id_d[i] = req_id_q[i];
        end
        if (alloc_fire_s) begin
            cmd_valid_d = 1'b1;
            cmd_id_d    = {req_id_q[alloc_action_id], alloc_action_id, alloc_sq_id};
            if (req_id_q[alloc_action_id] == REQ_LAST) begin
                req_id_d[alloc_action_id] = REQ_ZERO;
            end else begin
                req_id_d[alloc_action_id] = req_id_q[alloc_action_id] + REQ_ONE;
            end
        end else if (cmd_ready) begin
            cmd_valid_d = 1'b0;
        end else begin
            cmd_valid_d = cmd_valid_q;
        end
    end

    // Per-action hit vectors for allocation and retirement.
    always_comb begin
        alloc_hit_s  = {NUM_ACT{1'b0}};
        retire_hit_s = {NUM_ACT{1'b0}};
        for (int i = 0; i < NUM_ACT; i++) begin
            alloc_hit_s[i]  = alloc_fire_s & (alloc_action_id == ACTION_ID_BITS'(i));
            retire_hit_s[i] = retire_dec_s & (track_update_id_q == ACTION_ID_BITS'(i));
        end
    end

    // Outstanding counters; a simultaneous alloc and retire on one action cancel out.
    always_comb begin
        underflow_d   = underflow_q | (retire_fire_s & retire_empty_s);
        action_busy_d = {NUM_ACT{1'b0}};
        for (int i = 0; i < NUM_ACT; i++) begin
            if (alloc_hit_s[i] && !retire_hit_s[i]) begin
                outstanding_d[i] = outstanding_q[i] + CNT_ONE;
            end else if (!alloc_hit_s[i] && retire_hit_s[i]) begin
                outstanding_d[i] = outstanding_q[i] - CNT_ONE;
            end else begin
                outstanding_d[i] = outstanding_q[i];
            end
            action_busy_d[i] = (outstanding_d[i] != CNT_ZERO);
        end
    end

    // Retire FSM next state; outputs are registered from the next state.
    always_comb begin
        state_d           = state_q;
        track_update_id_d = track_update_id_q;
        cpl_rsp_data_d    = cpl_rsp_data_q;
        if (!track_init) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpl_req_valid) begin
                        track_update_id_d = cpl_req_id;
                        state_d           = S_UPD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_UPD: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (track_update_done) begin
                        cpl_rsp_data_d = track_update_data;
                        state_d        = S_RSP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_RSP: begin
                    if (cpl_rsp_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RSP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        track_update_d  = (state_d == S_UPD);
        cpl_rsp_valid_d = (state_d == S_RSP);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state_q           <= S_IDLE;
            cmd_valid_q       <= 1'b0;
            cmd_id_q          <= {CMD_BITS{1'b0}};
            track_update_q    <= 1'b0;
            track_update_id_q <= {ACTION_ID_BITS{1'b0}};
            cpl_rsp_valid_q   <= 1'b0;
            cpl_rsp_data_q    <= 2'b00;
            underflow_q       <= 1'b0;
            action_busy_q     <= {NUM_ACT{1'b0}};
            for (int i = 0; i < NUM_ACT; i++) begin
                req_id_q[i]      <= REQ_ZERO;
                outstanding_q[i] <= CNT_ZERO;
            end
        end else begin
            state_q           <= state_d;
            cmd_valid_q       <= cmd_valid_d;
            cmd_id_q          <= cmd_id_d;
            track_update_q    <= track_update_d;
            track_update_id_q <= track_update_id_d;
            cpl_rsp_valid_q   <= cpl_rsp_valid_d;
            cpl_rsp_data_q    <= cpl_rsp_data_d;
            underflow_q       <= underflow_d;
            action_busy_q     <= action_busy_d;
            for (int i = 0; i < NUM_ACT; i++) begin
                req_id_q[i]      <= req_id_d[i];
                outstanding_q[i] <= outstanding_d[i];
            end
        end
    end

    assign alloc_ready     = alloc_ready_s;
    assign cpl_req_ready   = cpl_req_ready_s;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_id          = cmd_id_q;
    assign track_update    = track_update_q;
    assign track_update_id = track_update_id_q;
    assign cpl_rsp_valid   = cpl_rsp_valid_q;
    assign cpl_rsp_data    = cpl_rsp_data_q;
    assign underflow_err   = underflow_q;
    assign action_busy     = action_busy_q;

endmodule

// File: tb/tb_nvme_cmd_id_alloc.sv
// -----------------------------------------------------------------------------
// Testbench for nvme_cmd_id_alloc. A transaction-level reference model tracks
// per-action outstanding counts and next req_id, the pending command, and the
// scheduled tracker exchange; the bench itself plays the tracker. Directed
// scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_nvme_cmd_id_alloc;

    localparam int AB = 4;
    localparam int QB = 4;
    localparam int RB = 8;
    localparam int TN = 8;
    localparam int NA = 16;

    logic        clk = 1'b0;
    logic        axi_aresetn;
    logic        track_init;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_action_id;
    logic [3:0]  alloc_sq_id;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_id;
    logic        cpl_req_valid;
    logic        cpl_req_ready;
    logic [3:0]  cpl_req_id;
    logic        cpl_rsp_valid;
    logic        cpl_rsp_ready;
    logic [1:0]  cpl_rsp_data;
    logic        track_update;
    logic [3:0]  track_update_id;
    logic        track_update_done;
    logic [1:0]  track_update_data;
    logic [15:0] action_busy;
    logic        underflow_err;

    always #5 clk = ~clk;

    nvme_cmd_id_alloc #(
        .ACTION_ID_BITS(AB), .QUEUE_ID_BITS(QB), .REQ_ID_BITS(RB), .TRACK_NUM(TN)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(axi_aresetn), .track_init(track_init),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_action_id(alloc_action_id), .alloc_sq_id(alloc_sq_id),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cpl_req_valid(cpl_req_valid), .cpl_req_ready(cpl_req_ready), .cpl_req_id(cpl_req_id),
        .cpl_rsp_valid(cpl_rsp_valid), .cpl_rsp_ready(cpl_rsp_ready), .cpl_rsp_data(cpl_rsp_data),
        .track_update(track_update), .track_update_id(track_update_id),
        .track_update_done(track_update_done), .track_update_data(track_update_data),
        .action_busy(action_busy), .underflow_err(underflow_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_out [NA];
    int m_req [NA];
    bit m_cmd_valid;
    int m_cmd_id;
    bit m_uflow;
    bit m_ret_active;
    int m_ret_aid;
    int m_pulse_at;
    int m_done_at;
    int m_done_data;
    bit m_rsp_valid;
    int m_rsp_data;
    int cyc;
    bit force_en;
    int force_data;

    function automatic void model_reset();
        for (int i = 0; i < NA; i++) begin
            m_out[i] = 0;
            m_req[i] = 0;
        end
        m_cmd_valid  = 1'b0;
        m_cmd_id     = 0;
        m_uflow      = 1'b0;
        m_ret_active = 1'b0;
        m_ret_aid    = 0;
        m_pulse_at   = -1;
        m_done_at    = -1;
        m_done_data  = 0;
        m_rsp_valid  = 1'b0;
        m_rsp_data   = 0;
    endfunction

    // Applies one clock edge worth of protocol rules to the model.
    function automatic void model_edge(input bit exp_ar, input bit exp_cr);
        bit ret_dec;
        int aid;
        ret_dec = 1'b0;
        if (!axi_aresetn) begin
            model_reset();
            return;
        end
        if (!track_init) begin
            m_ret_active = 1'b0;
            m_rsp_valid  = 1'b0;
        end else if (m_ret_active && cyc == m_done_at) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = m_done_data;
            if ((m_done_data & 1) != 0) begin
                if (m_out[m_ret_aid] == 0) m_uflow = 1'b1;
                else                       ret_dec = 1'b1;
            end
        end else if (m_rsp_valid && cpl_rsp_ready) begin
            m_rsp_valid  = 1'b0;
            m_ret_active = 1'b0;
        end else if (cpl_req_valid && exp_cr) begin
            m_ret_active = 1'b1;
            m_ret_aid    = int'(cpl_req_id);
            m_pulse_at   = cyc + 1;
            if (force_en) begin
                m_done_data = force_data;
                force_en    = 1'b0;
            end else if (m_out[m_ret_aid] > 0 && ($urandom % 2) == 1) begin
                m_done_data = 1 + 2 * int'($urandom % 2);
            end else begin
                m_done_data = 0;
            end
            // Tracker answers 3 cycles after the pulse with a completion, 1 without.
            m_done_at = m_pulse_at + (((m_done_data & 1) != 0) ? 3 : 1);
        end
        if (alloc_valid && exp_ar) begin
            aid         = int'(alloc_action_id);
            m_cmd_valid = 1'b1;
            m_cmd_id    = (m_req[aid] << 8) | (aid << 4) | int'(alloc_sq_id);
            m_req[aid]  = (m_req[aid] + 1) % TN;
            m_out[aid]  = m_out[aid] + 1;
        end else if (cmd_ready) begin
            m_cmd_valid = 1'b0;
        end
        if (ret_dec) m_out[m_ret_aid] = m_out[m_ret_aid] - 1;
    endfunction

    // One clock cycle: play tracker, compare every output, advance the model.
    task automatic step();
        bit          exp_ar;
        bit          exp_cr;
        logic [15:0] exp_busy;
        track_update_done = m_ret_active && (cyc == m_done_at);
        track_update_data = track_update_done ? 2'(m_done_data) : 2'b00;
        #3;
        exp_ar = axi_aresetn && track_init && (!m_cmd_valid || cmd_ready) &&
                 (m_out[alloc_action_id] < TN);
        exp_cr = axi_aresetn && track_init && !m_ret_active;
        for (int i = 0; i < NA; i++) exp_busy[i] = (m_out[i] != 0);
        check_eq("alloc_ready",   32'(alloc_ready),     32'(exp_ar));
        check_eq("cmd_valid",     32'(cmd_valid),       32'(m_cmd_valid));
        check_eq("cmd_id",        32'(cmd_id),          32'(m_cmd_id));
        check_eq("cpl_req_ready", 32'(cpl_req_ready),   32'(exp_cr));
        check_eq("cpl_rsp_valid", 32'(cpl_rsp_valid),   32'(m_rsp_valid));
        check_eq("cpl_rsp_data",  32'(cpl_rsp_data),    32'(m_rsp_data));
        check_eq("track_update",  32'(track_update),    32'(cyc == m_pulse_at));
        check_eq("track_upd_id",  32'(track_update_id), 32'(m_ret_aid));
        check_eq("action_busy",   32'(action_busy),     32'(exp_busy));
        check_eq("underflow_err", 32'(underflow_err),   32'(m_uflow));
        @(posedge clk);
        model_edge(exp_ar, exp_cr);
        cyc++;
        #1;
    endtask

    task automatic quiet();
        alloc_valid   = 1'b0;
        cmd_ready     = 1'b1;
        cpl_req_valid = 1'b0;
        cpl_rsp_ready = 1'b1;
    endtask

    task automatic alloc_n(input int aid, input int sq, input int n);
        alloc_valid     = 1'b1;
        alloc_action_id = 4'(aid);
        alloc_sq_id     = 4'(sq);
        cmd_ready       = 1'b1;
        for (int i = 0; i < n; i++) step();
        alloc_valid = 1'b0;
    endtask

    // Full retire exchange for one action with a chosen tracker result.
    task automatic do_retire(input int aid, input int data);
        int n;
        force_en      = 1'b1;
        force_data    = data;
        cpl_req_valid = 1'b1;
        cpl_req_id    = 4'(aid);
        cpl_rsp_ready = 1'b1;
        n = 0;
        while (!m_ret_active && n < 10) begin step(); n++; end
        cpl_req_valid = 1'b0;
        n = 0;
        while (m_ret_active && n < 20) begin step(); n++; end
        check_eq("retire_bound", 32'(n < 20), 32'd1);
        check_eq("rsp_data", 32'(cpl_rsp_data), 32'(data));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        axi_aresetn       = 1'b0;
        track_init        = 1'b1;
        alloc_action_id   = 4'd0;
        alloc_sq_id       = 4'd0;
        cpl_req_id        = 4'd0;
        track_update_done = 1'b0;
        track_update_data = 2'b00;
        force_en          = 1'b0;
        force_data        = 0;
        cyc               = 0;
        quiet();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state (outputs settled after two reset edges)
        check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_busy", 32'(action_busy), 32'd0);
        check_eq("rst_uflow", 32'(underflow_err), 32'd0);
        check_eq("rst_rsp_valid", 32'(cpl_rsp_valid), 32'd0);
        step();
        axi_aresetn = 1'b1;

        // 1: three ids for action 2, sq 5
        alloc_valid = 1'b1; alloc_action_id = 4'd2; alloc_sq_id = 4'd5;
        step(); check_eq("t1_id0", 32'(cmd_id), 32'h0025);
        step(); check_eq("t1_id1", 32'(cmd_id), 32'h0125);
        step(); check_eq("t1_id2", 32'(cmd_id), 32'h0225);
        alloc_valid = 1'b0;
        step(); check_eq("t1_busy2", 32'(action_busy[2]), 32'd1);

        // 2: fill action 1, other action still accepted, retire one, wrap to req_id 0
        alloc_n(1, 4, TN);
        alloc_valid = 1'b1; alloc_action_id = 4'd1;
        #1 check_eq("t2_full", 32'(alloc_ready), 32'd0);
        step();
        alloc_action_id = 4'd3; alloc_sq_id = 4'd0;
        #1 check_eq("t2_other", 32'(alloc_ready), 32'd1);
        step();
        alloc_valid = 1'b0;
        do_retire(1, 1);
        alloc_n(1, 7, 1);
        check_eq("t2_wrap", 32'(cmd_id), 32'h0017);

        // 3: nothing outstanding on action 4, no completion
        do_retire(4, 0);
        check_eq("t3_uflow", 32'(underflow_err), 32'd0);

        // 4: completion with error status on action 2
        do_retire(2, 3);
        check_eq("t4_busy2", 32'(action_busy[2]), 32'd1);

        // 5: alloc and retire on action 0 at the same edge with 4 outstanding
        alloc_n(0, 1, 4);
        quiet();
        force_en = 1'b1; force_data = 1;
        cpl_req_valid = 1'b1; cpl_req_id = 4'd0;
        step();
        cpl_req_valid = 1'b0;
        n = 0;
        while (cyc != m_done_at && n < 10) begin step(); n++; end
        alloc_valid = 1'b1; alloc_action_id = 4'd0; alloc_sq_id = 4'd3; cmd_ready = 1'b0;
        step();
        alloc_valid = 1'b0;
        check_eq("t5_cmd", 32'(cmd_id), 32'h0403);
        step();
        check_eq("t5_hold", 32'(cmd_id), 32'h0403);
        check_eq("t5_valid", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        n = 0;
        while (m_ret_active && n < 20) begin step(); n++; end
        alloc_n(0, 2, 4);
        alloc_action_id = 4'd0;
        #1 check_eq("t5_full", 32'(alloc_ready), 32'd0);
        step();

        // 6: forced underflow, then reset in the middle of WAIT
        do_retire(5, 1);
        check_eq("t6_uflow", 32'(underflow_err), 32'd1);
        force_en = 1'b1; force_data = 1;
        cpl_req_valid = 1'b1; cpl_req_id = 4'd2;
        step();
        cpl_req_valid = 1'b0;
        step();
        step();
        axi_aresetn = 1'b0;
        step();
        axi_aresetn = 1'b1;
        check_eq("t6_cmd_valid", 32'(cmd_valid), 32'd0);
        check_eq("t6_cmd_id", 32'(cmd_id), 32'd0);
        check_eq("t6_rsp_valid", 32'(cpl_rsp_valid), 32'd0);
        check_eq("t6_rsp_data", 32'(cpl_rsp_data), 32'd0);
        check_eq("t6_upd", 32'(track_update), 32'd0);
        check_eq("t6_upd_id", 32'(track_update_id), 32'd0);
        check_eq("t6_busy", 32'(action_busy), 32'd0);
        check_eq("t6_uflow_clr", 32'(underflow_err), 32'd0);
        #1 check_eq("t6_idle", 32'(cpl_req_ready), 32'd1);
        step();

        // Randomized traffic on a few actions so that full and wrap occur often
        for (int k = 0; k < 3000; k++) begin
            alloc_valid     = 1'($urandom % 2);
            alloc_action_id = 4'($urandom % 4);
            alloc_sq_id     = 4'($urandom);
            cmd_ready       = 1'(($urandom % 4) != 0);
            cpl_req_valid   = 1'(($urandom % 3) == 0);
            cpl_req_id      = 4'($urandom % 4);
            cpl_rsp_ready   = 1'($urandom % 2);
            track_init      = 1'(($urandom % 40) != 0);
            axi_aresetn     = 1'(($urandom % 500) != 0);
            step();
        end
        axi_aresetn = 1'b1;
        track_init  = 1'b1;
        quiet();
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
